reservation_station: RTL and testbench

- Receiving end of the dispatch handshake: accepts up to two dispatched uops per cycle into a small issue queue.
- Tracks source-operand readiness via writeback (CDB) tag broadcasts.
- Issues the oldest fully-ready uop to one functional unit.
- Produces the per-RS `stalled_full` bit that the hazard logic ORs into the pipeline stall.

---
 rtl/reservation_station_pkg.sv | 28 ++
 rtl/reservation_station_age_select.sv | 80 ++++++++
 rtl/reservation_station.sv | 201 ++++++++++++++++++++
 tb/tb_reservation_station.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reservation_station_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reservation_station_pkg
// Purpose  : Shared types and constants for the issue-queue reservation
//            station: the default physical tag / payload widths (shared with
//            rename and ROB) and the per-entry storage record.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package reservation_station_pkg;

  // Physical register tag width, shared with rename and ROB.
  localparam int RS_TAG_W     = 6;
  // Opaque uop payload width (opcode, dest tag, imm, ROB index).
  localparam int RS_PAYLOAD_W = 64;

  // One issue-queue slot.
  typedef struct packed {
    logic                    valid;
    logic [RS_TAG_W-1:0]     src1_tag;
    logic [RS_TAG_W-1:0]     src2_tag;
    logic                    src1_rdy;
    logic                    src2_rdy;
    logic [RS_PAYLOAD_W-1:0] payload;
  } rs_entry_s;

endpackage
`default_nettype wire

// File: rtl/reservation_station_age_select.sv
`default_nettype none
// ============================================================================
// Module   : rs_age_select
// Purpose  : Age matrix for the reservation station plus the oldest-ready
//            one-hot picker. age_q[i][j]=1 means entry i is older than j.
// Ports    : clk, rst_n          - clock, async active-low reset
//            valid_vec           - registered entry valid bits
//            alloc0_oh/alloc1_oh - entries written by dispatch slot 0 / 1
//            free_oh             - entry retired by issue this cycle
//            cand                - valid entries with both sources ready
//            grant               - one-hot oldest candidate
// Revision : 1.0 - initial release
// ============================================================================
module rs_age_select #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DEPTH-1:0] valid_vec,
  input  logic [DEPTH-1:0] alloc0_oh,
  input  logic [DEPTH-1:0] alloc1_oh,
  input  logic [DEPTH-1:0] free_oh,
  input  logic [DEPTH-1:0] cand,
  output logic [DEPTH-1:0] grant
);

  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];
  logic [DEPTH-1:0] new_oh;
  logic [DEPTH-1:0] keep_vec;
  logic [DEPTH-1:0] blocked;

  // A newly written row is younger than everything, except that slot 0 is
  // older than slot 1 when both land together. A newly written column is
  // younger than every entry that survives this edge. Retired rows/columns
  // are cleared so stale bits never leak into a later allocation.
  always_comb begin
    new_oh   = alloc0_oh | alloc1_oh;
    keep_vec = valid_vec & ~free_oh;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        age_d[i][j] = age_q[i][j];
        if (new_oh[i]) begin
          age_d[i][j] = alloc0_oh[i] & alloc1_oh[j];
        end else if (new_oh[j]) begin
          age_d[i][j] = keep_vec[i];
        end else if (free_oh[i] || free_oh[j]) begin
          age_d[i][j] = 1'b0;
        end
      end
    end
  end

  // A candidate is blocked if any other candidate is older than it.
  always_comb begin
    blocked = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (cand[j] && age_q[j][i]) begin
          blocked[i] = 1'b1;
        end
      end
    end
    grant = cand & ~blocked;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/reservation_station.sv
`default_nettype none
// ============================================================================
// Module   : reservation_station
// Purpose  : Small issue queue. Accepts up to two dispatched uops per cycle,
//            tracks operand readiness from CDB tag broadcasts, and issues
//            the oldest fully-ready uop to one functional unit.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            disp_valid[0:1]            - per-slot dispatch valid (slot 0 older)
//            disp_src{1,2}_tag/_rdy     - per-slot source tags / ready flags,
//                                         slot s in bits [s*W +: W]
//            disp_payload               - per-slot opaque payload
//            wb_valid, wb_tag           - CDB broadcasts, bus k in [k*TAG_W +: TAG_W]
//            flush                      - discard every entry
//            issue_ready                - FU accepts this cycle
//            issue_valid, issue_payload - selected uop (payload 0 when idle)
//            stalled_full               - fewer than two free entries
//            free_cnt                   - registered free-entry count
//            DEPTH must be a power of two and at least 2.
// Revision : 1.0 - initial release
// ============================================================================
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int TAG_W     = RS_TAG_W,
  parameter int PAYLOAD_W = RS_PAYLOAD_W,
  parameter int N_CDB     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [0:1]             disp_valid,
  input  logic [2*TAG_W-1:0]     disp_src1_tag,
  input  logic [2*TAG_W-1:0]     disp_src2_tag,
  input  logic [1:0]             disp_src1_rdy,
  input  logic [1:0]             disp_src2_rdy,
  input  logic [2*PAYLOAD_W-1:0] disp_payload,
  input  logic [N_CDB-1:0]       wb_valid,
  input  logic [N_CDB*TAG_W-1:0] wb_tag,
  input  logic                   flush,
  input  logic                   issue_ready,
  output logic                   issue_valid,
  output logic [PAYLOAD_W-1:0]   issue_payload,
  output logic                   stalled_full,
  output logic [$clog2(DEPTH):0] free_cnt
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  rs_entry_s        ent_q [DEPTH];
  rs_entry_s        ent_d [DEPTH];
  logic [CNT_W-1:0] free_cnt_q;
  logic [CNT_W-1:0] free_cnt_d;

  logic [DEPTH-1:0]     valid_vec;
  logic [DEPTH-1:0]     free_vec;
  logic [DEPTH-1:0]     avail1_vec;
  logic [1:0]           slot_want;
  logic [DEPTH-1:0]     alloc_oh [2];
  logic                 drop;
  logic [DEPTH-1:0]     cand;
  logic [DEPTH-1:0]     grant;
  logic [DEPTH-1:0]     free_oh;
  logic                 issue_fire;
  logic [PAYLOAD_W-1:0] sel_payload;

  // True if any valid CDB carries this tag this cycle.
  function automatic logic wb_hit(input logic [N_CDB-1:0]       v,
                                  input logic [N_CDB*TAG_W-1:0] t,
                                  input logic [TAG_W-1:0]       tag);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < N_CDB; k++) begin
      if (v[k] && (t[k*TAG_W +: TAG_W] == tag)) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

  function automatic logic [DEPTH-1:0] lowest_one(input logic [DEPTH-1:0] v);
    return v & (~v + DEPTH'(1));
  endfunction

  // Free set comes from registered valids only: an entry issuing this cycle
  // is not handed out again until the next cycle.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = ent_q[i].valid;
    end
    free_vec    = ~valid_vec;
    slot_want   = {disp_valid[1] & ~flush, disp_valid[0] & ~flush};
    alloc_oh[0] = slot_want[0] ? lowest_one(free_vec) : '0;
    avail1_vec  = free_vec & ~alloc_oh[0];
    alloc_oh[1] = slot_want[1] ? lowest_one(avail1_vec) : '0;
    drop        = (slot_want[0] && (free_vec == '0)) ||
                  (slot_want[1] && (avail1_vec == '0));
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cand[i] = ent_q[i].valid & ent_q[i].src1_rdy & ent_q[i].src2_rdy;
    end
  end

  rs_age_select #(
    .DEPTH (DEPTH)
  ) u_age_select (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_vec (valid_vec),
    .alloc0_oh (alloc_oh[0]),
    .alloc1_oh (alloc_oh[1]),
    .free_oh   (free_oh),
    .cand      (cand),
    .grant     (grant)
  );

  assign issue_valid = (|cand) & ~flush;
  assign issue_fire  = issue_valid & issue_ready;
  assign free_oh     = issue_fire ? grant : '0;

  always_comb begin
    sel_payload = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        sel_payload = sel_payload | ent_q[i].payload;
      end
    end
  end

  assign issue_payload = issue_valid ? sel_payload : '0;

  // Entry update: wakeup, retire, allocate (with same-cycle CDB bypass),
  // and finally flush overriding everything.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].valid) begin
        if (wb_hit(wb_valid, wb_tag, ent_q[i].src1_tag)) ent_d[i].src1_rdy = 1'b1;
        if (wb_hit(wb_valid, wb_tag, ent_q[i].src2_tag)) ent_d[i].src2_rdy = 1'b1;
      end
      if (free_oh[i]) begin
        ent_d[i].valid = 1'b0;
      end
      for (int s = 0; s < 2; s++) begin
        if (alloc_oh[s][i]) begin
          ent_d[i].valid    = 1'b1;
          ent_d[i].src1_tag = disp_src1_tag[s*TAG_W +: TAG_W];
          ent_d[i].src2_tag = disp_src2_tag[s*TAG_W +: TAG_W];
          ent_d[i].src1_rdy = disp_src1_rdy[s] |
                              wb_hit(wb_valid, wb_tag, disp_src1_tag[s*TAG_W +: TAG_W]);
          ent_d[i].src2_rdy = disp_src2_rdy[s] |
                              wb_hit(wb_valid, wb_tag, disp_src2_tag[s*TAG_W +: TAG_W]);
          ent_d[i].payload  = disp_payload[s*PAYLOAD_W +: PAYLOAD_W];
        end
      end
      if (flush) begin
        ent_d[i].valid = 1'b0;
      end
    end
  end

  // Counts only what was actually written, so a dropped overflow slot does
  // not desynchronise the count from the entry array.
  always_comb begin
    if (flush) begin
      free_cnt_d = CNT_W'(DEPTH);
    end else begin
      free_cnt_d = free_cnt_q
                 - CNT_W'(|alloc_oh[0])
                 - CNT_W'(|alloc_oh[1])
                 + CNT_W'(issue_fire);
    end
  end

  assign free_cnt     = free_cnt_q;
  assign stalled_full = (free_cnt_q < CNT_W'(2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      free_cnt_q <= CNT_W'(DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      free_cnt_q <= free_cnt_d;
    end
  end

`ifndef SYNTHESIS
  // Dispatching past a full queue drops the overflowing slot.
  a_no_dispatch_overflow: assert property (
    @(posedge clk) disable iff (!rst_n) !drop
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_reservation_station.sv
`default_nettype none
// ============================================================================
// Module   : tb_reservation_station
// Purpose  : Directed, self-checking bench for reservation_station: a table
//            of per-cycle vectors plus hand-written fill/flush sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reservation_station;

  logic         clk;
  logic         rst_n;
  logic [0:1]   disp_valid;
  logic [11:0]  disp_src1_tag;
  logic [11:0]  disp_src2_tag;
  logic [1:0]   disp_src1_rdy;
  logic [1:0]   disp_src2_rdy;
  logic [127:0] disp_payload;
  logic [1:0]   wb_valid;
  logic [11:0]  wb_tag;
  logic         flush;
  logic         issue_ready;
  logic         issue_valid;
  logic [63:0]  issue_payload;
  logic         stalled_full;
  logic [3:0]   free_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  reservation_station #(
    .DEPTH     (8),
    .TAG_W     (6),
    .PAYLOAD_W (64),
    .N_CDB     (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .disp_valid    (disp_valid),
    .disp_src1_tag (disp_src1_tag),
    .disp_src2_tag (disp_src2_tag),
    .disp_src1_rdy (disp_src1_rdy),
    .disp_src2_rdy (disp_src2_rdy),
    .disp_payload  (disp_payload),
    .wb_valid      (wb_valid),
    .wb_tag        (wb_tag),
    .flush         (flush),
    .issue_ready   (issue_ready),
    .issue_valid   (issue_valid),
    .issue_payload (issue_payload),
    .stalled_full  (stalled_full),
    .free_cnt      (free_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        s0v;
    logic [5:0]  s0t1;
    logic [5:0]  s0t2;
    logic        s0r1;
    logic        s0r2;
    logic [63:0] s0p;
    logic        s1v;
    logic [5:0]  s1t1;
    logic [5:0]  s1t2;
    logic        s1r1;
    logic        s1r2;
    logic [63:0] s1p;
    logic [1:0]  wbv;
    logic [5:0]  wb0;
    logic [5:0]  wb1;
    logic        ir;
    logic        e_iv;
    logic [63:0] e_pay;
    logic        e_sf;
    logic [3:0]  e_fc;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t vx(input logic ir, input logic e_iv,
                              input logic [63:0] e_pay, input logic [3:0] e_fc);
    vec_t v;
    v       = '0;
    v.ir    = ir;
    v.e_iv  = e_iv;
    v.e_pay = e_pay;
    v.e_sf  = 1'b0;
    v.e_fc  = e_fc;
    return v;
  endfunction

  function automatic vec_t s0(input vec_t vi, input logic [5:0] t1, input logic [5:0] t2,
                              input logic r1, input logic r2, input logic [63:0] p);
    vec_t v;
    v = vi;
    v.s0v = 1'b1; v.s0t1 = t1; v.s0t2 = t2; v.s0r1 = r1; v.s0r2 = r2; v.s0p = p;
    return v;
  endfunction

  function automatic vec_t s1(input vec_t vi, input logic [5:0] t1, input logic [5:0] t2,
                              input logic r1, input logic r2, input logic [63:0] p);
    vec_t v;
    v = vi;
    v.s1v = 1'b1; v.s1t1 = t1; v.s1t2 = t2; v.s1r1 = r1; v.s1r2 = r2; v.s1p = p;
    return v;
  endfunction

  function automatic vec_t wb(input vec_t vi, input logic [1:0] wbv,
                              input logic [5:0] t0, input logic [5:0] t1);
    vec_t v;
    v = vi;
    v.wbv = wbv; v.wb0 = t0; v.wb1 = t1;
    return v;
  endfunction

  task automatic drive_idle();
    disp_valid    = 2'b00;
    disp_src1_tag = '0;
    disp_src2_tag = '0;
    disp_src1_rdy = '0;
    disp_src2_rdy = '0;
    disp_payload  = '0;
    wb_valid      = '0;
    wb_tag        = '0;
    flush         = 1'b0;
    issue_ready   = 1'b0;
  endtask

  task automatic set_slot(input int s, input logic [5:0] t1, input logic [5:0] t2,
                          input logic r1, input logic r2, input logic [63:0] p);
    disp_valid[s]           = 1'b1;
    disp_src1_tag[s*6 +: 6] = t1;
    disp_src2_tag[s*6 +: 6] = t2;
    disp_src1_rdy[s]        = r1;
    disp_src2_rdy[s]        = r2;
    disp_payload[s*64 +: 64] = p;
  endtask

  task automatic apply(input vec_t v);
    drive_idle();
    if (v.s0v) set_slot(0, v.s0t1, v.s0t2, v.s0r1, v.s0r2, v.s0p);
    if (v.s1v) set_slot(1, v.s1t1, v.s1t2, v.s1r1, v.s1r2, v.s1p);
    wb_valid    = v.wbv;
    wb_tag      = {v.wb1, v.wb0};
    issue_ready = v.ir;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_iv, input logic [63:0] e_pay,
                            input logic e_sf, input logic [3:0] e_fc);
    check({tag, "_issue_valid"},   64'(issue_valid),  64'(e_iv));
    check({tag, "_issue_payload"}, issue_payload,     e_pay);
    check({tag, "_stalled_full"},  64'(stalled_full), 64'(e_sf));
    check({tag, "_free_cnt"},      64'(free_cnt),     64'(e_fc));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Single ready uop: issues the cycle after dispatch.
    tbl.push_back(vx(1, 0, 64'h0, 8));
    tbl.push_back(s0(vx(1, 0, 64'h0, 8), 6'd0, 6'd0, 1, 1, 64'hA));
    tbl.push_back(vx(1, 1, 64'hA, 7));
    tbl.push_back(vx(1, 0, 64'h0, 8));
    // src2 tag 5 woken three cycles after dispatch, issues one cycle later.
    tbl.push_back(s0(vx(1, 0, 64'h0, 8), 6'd1, 6'd5, 1, 0, 64'hB));
    tbl.push_back(vx(1, 0, 64'h0, 7));
    tbl.push_back(vx(1, 0, 64'h0, 7));
    tbl.push_back(wb(vx(1, 0, 64'h0, 7), 2'b01, 6'd5, 6'd0));
    tbl.push_back(vx(1, 1, 64'hB, 7));
    tbl.push_back(vx(1, 0, 64'h0, 8));
    // Same-cycle bypass on CDB1 for src1 tag 9.
    tbl.push_back(wb(s0(vx(1, 0, 64'h0, 8), 6'd9, 6'd3, 0, 1, 64'hC), 2'b10, 6'd0, 6'd9));
    tbl.push_back(vx(1, 1, 64'hC, 7));
    tbl.push_back(vx(1, 0, 64'h0, 8));
    // A (slot0), B (slot1) waiting; C ready; C held while FU busy; order C, A, B.
    tbl.push_back(s1(s0(vx(1, 0, 64'h0, 8), 6'h10, 6'd2, 0, 1, 64'hA1),
                     6'h11, 6'd3, 0, 1, 64'hB1));
    tbl.push_back(s0(vx(0, 0, 64'h0, 6), 6'd0, 6'd0, 1, 1, 64'hC1));
    tbl.push_back(vx(0, 1, 64'hC1, 5));
    tbl.push_back(wb(vx(1, 1, 64'hC1, 5), 2'b11, 6'h10, 6'h11));
    tbl.push_back(vx(1, 1, 64'hA1, 6));
    tbl.push_back(vx(1, 1, 64'hB1, 7));
    tbl.push_back(vx(1, 0, 64'h0, 8));

    drive_idle();
    rst_n = 1'b0;
    #12;
    check_outs("reset", 1'b0, 64'h0, 1'b0, 4'd8);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      #1;
      check_outs($sformatf("vec%0d", i), tbl[i].e_iv, tbl[i].e_pay, tbl[i].e_sf, tbl[i].e_fc);
      tick();
    end

    // Fill seven entries, none ready: entry k waits on src1 tag 0x20+k.
    for (int c = 0; c < 4; c++) begin
      drive_idle();
      issue_ready = 1'b1;
      set_slot(0, 6'h20 + 6'(2*c), 6'h00, 1'b0, 1'b1, 64'h100 + 64'(2*c));
      if (c < 3) set_slot(1, 6'h21 + 6'(2*c), 6'h00, 1'b0, 1'b1, 64'h101 + 64'(2*c));
      #1;
      check_outs($sformatf("fill%0d", c), 1'b0, 64'h0, 1'b0, 4'(8 - 2*c));
      tick();
    end

    drive_idle(); issue_ready = 1'b1; #1;
    check_outs("full7", 1'b0, 64'h0, 1'b1, 4'd1);
    tick();

    drive_idle(); issue_ready = 1'b1; wb_valid = 2'b01; wb_tag[5:0] = 6'h23; #1;
    check_outs("wake3", 1'b0, 64'h0, 1'b1, 4'd1);
    tick();

    drive_idle(); issue_ready = 1'b1; #1;
    check_outs("issue3", 1'b1, 64'h103, 1'b1, 4'd1);
    tick();

    drive_idle(); #1;
    check_outs("after3", 1'b0, 64'h0, 1'b0, 4'd2);
    tick();

    // Two ready uops land in entries 3 and 7 while older entry 6 wakes:
    // the older entry must win despite its higher index.
    drive_idle();
    set_slot(0, 6'h00, 6'h00, 1'b1, 1'b1, 64'h200);
    set_slot(1, 6'h00, 6'h00, 1'b1, 1'b1, 64'h201);
    wb_valid = 2'b01; wb_tag[5:0] = 6'h26; #1;
    check_outs("fillfull", 1'b0, 64'h0, 1'b0, 4'd2);
    tick();

    drive_idle(); issue_ready = 1'b1; #1;
    check_outs("full_sel", 1'b1, 64'h106, 1'b1, 4'd0);
    flush = 1'b1; #1;
    check_outs("flush", 1'b0, 64'h0, 1'b1, 4'd0);
    tick();

    drive_idle(); issue_ready = 1'b1; #1;
    check_outs("postflush", 1'b0, 64'h0, 1'b0, 4'd8);
    set_slot(0, 6'h00, 6'h00, 1'b1, 1'b1, 64'h300);
    flush = 1'b1; #1;
    check("flush_disp_issue_valid", 64'(issue_valid), 64'h0);
    tick();

    drive_idle(); issue_ready = 1'b1; #1;
    check_outs("flush_disp", 1'b0, 64'h0, 1'b0, 4'd8);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
